// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle datapath: fetch, decode, ALU, load/store and CBZ sequencing.
// Build option: define ILLEGAL_TRAP_EN to park illegal opcodes in TRAP until reset.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Op,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        InstrRead,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCSrc,
   output logic        Reg2Loc,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [1:0]  ALUOp,
   output logic [3:0]  state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      ALU_WB   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WB   = 4'd7,
      MEM_WR   = 4'd8,
      BRANCH   = 4'd9,
      TRAP     = 4'd10
   } state_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   state_t state;
   state_t next_state;
   logic   imm_hold;
   logic   is_r;
   logic   is_i;
   logic   is_mem;
   logic   is_cbz;

   always_comb begin
      is_r   = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR);
      is_i   = (Op[10:1] == OP_ADDI) || (Op[10:1] == OP_SUBI);
      is_mem = (Op == OP_LDUR) || (Op == OP_STUR);
      is_cbz = (Op[10:3] == OP_CBZ);
   end

   // imm_hold remembers which EXEC state ran so ALU_WB keeps the same ALU setup.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FETCH;
         imm_hold <= 1'b0;
      end else begin
         state <= next_state;
         if (state == EXEC_R) begin
            imm_hold <= 1'b0;
         end else if (state == EXEC_I) begin
            imm_hold <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:    next_state = mem_ready ? DECODE : FETCH;
         DECODE: begin
            if (is_r)        next_state = EXEC_R;
            else if (is_i)   next_state = EXEC_I;
            else if (is_mem) next_state = MEM_ADDR;
            else if (is_cbz) next_state = BRANCH;
            else begin
`ifdef ILLEGAL_TRAP_EN
               next_state = TRAP;
`else
               next_state = FETCH;
`endif
            end
         end
         EXEC_R:   next_state = ALU_WB;
         EXEC_I:   next_state = ALU_WB;
         ALU_WB:   next_state = FETCH;
         MEM_ADDR: next_state = (Op == OP_LDUR) ? MEM_RD : MEM_WR;
         MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
         MEM_WB:   next_state = FETCH;
         MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
         BRANCH:   next_state = FETCH;
`ifdef ILLEGAL_TRAP_EN
         TRAP:     next_state = TRAP;
`endif
         default:  next_state = FETCH;
      endcase
   end

   // Strobes come from the state alone except the fetch handshake and the CBZ
   // PC update; reset masks them combinationally so an aborted access stops at once.
   always_comb begin
      InstrRead = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      Reg2Loc   = 1'b0;
      ALUSrc    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUOp     = 2'b00;
      case (state)
         FETCH: begin
            InstrRead = 1'b1;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
         end
         EXEC_R: ALUOp = 2'b10;
         EXEC_I: begin
            ALUOp  = 2'b11;
            ALUSrc = 1'b1;
         end
         ALU_WB: begin
            RegWrite = 1'b1;
            ALUSrc   = imm_hold;
            ALUOp    = imm_hold ? 2'b11 : 2'b10;
         end
         MEM_ADDR: ALUSrc = 1'b1;
         MEM_RD: begin
            MemRead = 1'b1;
            ALUSrc  = 1'b1;
         end
         MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEM_WR: begin
            MemWrite = 1'b1;
            Reg2Loc  = 1'b1;
            ALUSrc   = 1'b1;
         end
         BRANCH: begin
            Reg2Loc = 1'b1;
            ALUOp   = 2'b01;
            PCWrite = Zero;
            PCSrc   = Zero;
         end
         default: ;
      endcase
      if (!reset) begin
         InstrRead = 1'b0;
         IRWrite   = 1'b0;
         PCWrite   = 1'b0;
         PCSrc     = 1'b0;
         Reg2Loc   = 1'b0;
         ALUSrc    = 1'b0;
         MemtoReg  = 1'b0;
         RegWrite  = 1'b0;
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         ALUOp     = 2'b00;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written corner
// sequences and randomized instructions checked against an instruction-level model.
module tb_multicycle_ctrl;

   localparam logic [10:0] ADD_OP  = 11'b10001011000;
   localparam logic [10:0] SUB_OP  = 11'b11001011000;
   localparam logic [10:0] AND_OP  = 11'b10001010000;
   localparam logic [10:0] ORR_OP  = 11'b10101010000;
   localparam logic [10:0] ADDI_OP = 11'b10010001001;
   localparam logic [10:0] SUBI_OP = 11'b11010001000;
   localparam logic [10:0] LDUR_OP = 11'b11111000010;
   localparam logic [10:0] STUR_OP = 11'b11111000000;
   localparam logic [10:0] CBZ_OP  = 11'b10110100101;
   localparam logic [10:0] BAD_OP  = 11'b11111111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] Op;
   logic        Zero;
   logic        mem_ready;
   logic        InstrRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
   logic        MemtoReg, RegWrite, MemRead, MemWrite;
   logic [1:0]  ALUOp;
   logic [3:0]  state_o;
   logic [11:0] outs;

   int errors = 0;
   int checks = 0;

   logic [3:0]  planState[$];
   logic        planMr[$];
   logic        planZero[$];
   logic [10:0] planOp;

   typedef struct {
      logic [10:0] op;
      logic        zero;
      int          len;
      logic [31:0] seq;
      logic [7:0]  mr;
   } vec_t;

   vec_t vecs[10];

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
      .InstrRead(InstrRead), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
      .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign outs = {InstrRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc,
                  MemtoReg, RegWrite, MemRead, MemWrite, ALUOp};

   task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Instruction class from the opcode rules: 0 illegal, 1 R, 2 I, 3 load, 4 store, 5 CBZ.
   function automatic int classify(input logic [10:0] op);
      logic [10:0] masks [9] = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FE, 11'h7FE,
                                 11'h7FF, 11'h7FF, 11'h7F8};
      logic [10:0] vals  [9] = '{ADD_OP, SUB_OP, AND_OP, ORR_OP, 11'b10010001000,
                                 11'b11010001000, LDUR_OP, STUR_OP, 11'b10110100000};
      int          cls   [9] = '{1, 1, 1, 1, 2, 2, 3, 4, 5};
      for (int k = 0; k < 9; k++) begin
         if ((op & masks[k]) == vals[k]) return cls[k];
      end
      return 0;
   endfunction

   // Expected strobes for one cycle; ALU_WB repeats the ALU setup of the cycle before it.
   function automatic logic [11:0] expOut(input logic [3:0] s, input logic m, input logic z,
                                          input logic [11:0] prev);
      logic [11:0] e;
      e = '0;
      case (s)
         4'd0: begin e[11] = 1'b1; e[10] = m; e[9] = m; end
         4'd2: e[1:0] = 2'b10;
         4'd3: begin e[1:0] = 2'b11; e[6] = 1'b1; end
         4'd4: begin e[4] = 1'b1; e[6] = prev[6]; e[1:0] = prev[1:0]; end
         4'd5: e[6] = 1'b1;
         4'd6: begin e[3] = 1'b1; e[6] = 1'b1; end
         4'd7: begin e[4] = 1'b1; e[5] = 1'b1; end
         4'd8: begin e[2] = 1'b1; e[7] = 1'b1; e[6] = 1'b1; end
         4'd9: begin e[7] = 1'b1; e[1:0] = 2'b01; e[9] = z; e[8] = z; end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic push(input logic [3:0] s, input logic m, input logic z);
      planState.push_back(s);
      planMr.push_back(m);
      planZero.push_back(z);
   endtask

   task automatic applyStimulus();
      logic [11:0] prev;
      logic [11:0] exp;
      logic [3:0]  s;
      logic        m, z;
      bit          first;
      prev  = '0;
      first = 1'b1;
      while (planState.size() > 0) begin
         s = planState.pop_front();
         m = planMr.pop_front();
         z = planZero.pop_front();
         @(negedge clk);
         if (first) Op = planOp;
         first     = 1'b0;
         mem_ready = m;
         Zero      = z;
         #1;
         exp = expOut(s, m, z, prev);
         checkOutput("state", {8'd0, state_o}, {8'd0, s});
         checkOutput("strobes", outs, exp);
         prev = exp;
      end
   endtask

   task automatic doReset();
      reset     = 1'b0;
      mem_ready = 1'b0;
      Zero      = 1'b0;
      #1;
      checkOutput("reset_strobes", outs, 12'h000);
      checkOutput("reset_state", {8'd0, state_o}, 12'h000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Model: expand one instruction into its per-cycle states from class and wait counts.
   task automatic buildPlan(input logic [10:0] op, input logic z, input int fw, input int mw,
                            output bit trapped);
      int cls;
      cls     = classify(op);
      trapped = 1'b0;
      planOp  = op;
      repeat (fw) push(4'd0, 1'b0, 1'($urandom));
      push(4'd0, 1'b1, 1'($urandom));
      push(4'd1, 1'($urandom), 1'($urandom));
      case (cls)
         1: begin push(4'd2, 1'($urandom), 1'($urandom)); push(4'd4, 1'($urandom), 1'($urandom)); end
         2: begin push(4'd3, 1'($urandom), 1'($urandom)); push(4'd4, 1'($urandom), 1'($urandom)); end
         3: begin
            push(4'd5, 1'($urandom), 1'($urandom));
            repeat (mw) push(4'd6, 1'b0, 1'($urandom));
            push(4'd6, 1'b1, 1'($urandom));
            push(4'd7, 1'($urandom), 1'($urandom));
         end
         4: begin
            push(4'd5, 1'($urandom), 1'($urandom));
            repeat (mw) push(4'd8, 1'b0, 1'($urandom));
            push(4'd8, 1'b1, 1'($urandom));
         end
         5: push(4'd9, 1'($urandom), z);
         default: begin
`ifdef ILLEGAL_TRAP_EN
            repeat (3) push(4'd10, 1'($urandom), 1'($urandom));
            trapped = 1'b1;
`endif
         end
      endcase
   endtask

   initial begin
      logic [10:0] pool [10];
      logic [10:0] rop;
      bit          trapped;

      vecs[0] = '{ADD_OP,  1'b0, 4, 32'h00004210, 8'hFF};
      vecs[1] = '{LDUR_OP, 1'b0, 7, 32'h07666510, 8'hE7};
      vecs[2] = '{CBZ_OP,  1'b1, 3, 32'h00000910, 8'hFF};
      vecs[3] = '{CBZ_OP,  1'b0, 3, 32'h00000910, 8'hFF};
      vecs[4] = '{STUR_OP, 1'b0, 4, 32'h00008510, 8'hFF};
      vecs[5] = '{ADDI_OP, 1'b0, 4, 32'h00004310, 8'hFF};
      vecs[6] = '{SUBI_OP, 1'b1, 4, 32'h00004310, 8'hFF};
      vecs[7] = '{ORR_OP,  1'b0, 5, 32'h00042100, 8'hFE};
      vecs[8] = '{STUR_OP, 1'b1, 5, 32'h00088510, 8'hF7};
      vecs[9] = '{LDUR_OP, 1'b0, 5, 32'h00076510, 8'hFF};

      reset     = 1'b0;
      mem_ready = 1'b1;
      Zero      = 1'b0;
      Op        = ADD_OP;
      #3;
      checkOutput("reset_strobes", outs, 12'h000);
      checkOutput("reset_state", {8'd0, state_o}, 12'h000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("first_fetch_state", {8'd0, state_o}, 12'h000);
      checkOutput("first_fetch_strobes", outs, 12'hE00);
      mem_ready = 1'b0;

      for (int v = 0; v < 10; v++) begin
         planOp = vecs[v].op;
         for (int c = 0; c < vecs[v].len; c++) begin
            push(vecs[v].seq[4*c +: 4], vecs[v].mr[c], vecs[v].zero);
         end
         applyStimulus();
      end

      // Store aborted by reset while still waiting on memory.
      planOp = STUR_OP;
      push(4'd0, 1'b1, 1'b0);
      push(4'd1, 1'b1, 1'b0);
      push(4'd5, 1'b0, 1'b0);
      push(4'd8, 1'b0, 1'b0);
      applyStimulus();
      doReset();

      // Illegal opcode handling.
      planOp = BAD_OP;
      push(4'd0, 1'b1, 1'b0);
      push(4'd1, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      repeat (20) push(4'd10, 1'($urandom), 1'($urandom));
      applyStimulus();
      doReset();
`else
      push(4'd0, 1'b0, 1'b0);
      applyStimulus();
`endif

      pool = '{ADD_OP, SUB_OP, AND_OP, ORR_OP, ADDI_OP, SUBI_OP, LDUR_OP, STUR_OP, CBZ_OP, BAD_OP};
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0: rop = 11'($urandom_range(0, 2047));
            1: rop = {8'b10110100, 3'($urandom)};
            2: rop = {pool[$urandom_range(4, 5)][10:1], 1'($urandom)};
            default: rop = pool[$urandom_range(0, 9)];
         endcase
         buildPlan(rop, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), trapped);
         applyStimulus();
         if (trapped) doReset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
